// File: rtl/m_game_sequencer.sv
// m_game_sequencer
//   Top-level game-state sequencer. It walks the game through its phases (greeting, idle,
//   wait-for-tick, logic, render, respawn, paused, game over). It owns the lives counter,
//   pause request and per-phase watchdog, and muxes the VGA pixel bus from the active
//   sub-renderer.
// Ports
//   clock, resetn              system clock, asynchronous active-low reset
//   enable                     global advance enable; 0 freezes all state
//   key_valid, key_code        1-cycle key strobe with decoded key code
//   frame_tick                 1-cycle pacing strobe, one per game step
//   e_greet .. e_game_over     Moore enables for the sub-modules
//   *_done, collided           finished pulses from the sub-modules; collided valid with logic_done
//   src_x/y/color/write        {over,play,greet} pixel buses from the renderers
//   VGA_X/Y/COLOR/WRITE        muxed pixel bus
//   lives, state_out           remaining lives, current state encoding
//   err_timeout                sticky watchdog flag, cleared by the next game start
module m_game_sequencer #(
  parameter int unsigned X_W       = 8,
  parameter int unsigned Y_W       = 7,
  parameter int unsigned COLOR_W   = 12,
  parameter int unsigned LIVES     = 3,
  parameter int unsigned LIFE_W    = 2,
  parameter logic [7:0]  START_KEY = 8'h29,
  parameter logic [7:0]  PAUSE_KEY = 8'h4D,
  parameter int unsigned WDOG      = 2**20
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic                   key_valid,
  input  logic [7:0]             key_code,
  input  logic                   frame_tick,
  output logic                   e_greet,
  output logic                   e_logic,
  output logic                   e_render,
  output logic                   e_respawn,
  output logic                   e_game_over,
  input  logic                   greet_done,
  input  logic                   logic_done,
  input  logic                   render_done,
  input  logic                   respawn_done,
  input  logic                   game_over_done,
  input  logic                   collided,
  input  logic [3*X_W-1:0]       src_x,
  input  logic [3*Y_W-1:0]       src_y,
  input  logic [3*COLOR_W-1:0]   src_color,
  input  logic [2:0]             src_write,
  output logic [X_W-1:0]         VGA_X,
  output logic [Y_W-1:0]         VGA_Y,
  output logic [COLOR_W-1:0]     VGA_COLOR,
  output logic                   VGA_WRITE,
  output logic [LIFE_W-1:0]      lives,
  output logic [2:0]             state_out,
  output logic                   err_timeout
);

  typedef enum logic [2:0] {
    StGreeting = 3'd0,
    StIdle     = 3'd1,
    StWait     = 3'd2,
    StLogic    = 3'd3,
    StRender   = 3'd4,
    StRespawn  = 3'd5,
    StPaused   = 3'd6,
    StGameOver = 3'd7
  } state_e;

  // Wraps harmlessly when WDOG is 0; the watchdog is disabled in that case.
  localparam logic [31:0] WdogLast = 32'(WDOG - 1);

  state_e              r_state, w_state_d;
  logic [LIFE_W-1:0]   r_lives, w_lives_d;
  logic                r_err, w_err_d;
  logic                r_pend, w_pend_d;
  logic [31:0]         r_wdog, w_wdog_d;
  logic                w_timeout;
  logic                w_start_key;
  logic                w_pause_key;
  logic                w_busy;

  assign w_start_key = key_valid && (key_code == START_KEY);
  assign w_pause_key = key_valid && (key_code == PAUSE_KEY);

  // Phases that wait on a sub-module and so are guarded by the watchdog.
  assign w_busy = (r_state == StGreeting) || (r_state == StLogic) || (r_state == StRender) ||
                  (r_state == StRespawn) || (r_state == StGameOver);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= StGreeting;
      r_lives <= '0;
      r_err   <= 1'b0;
      r_pend  <= 1'b0;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_d;
      r_lives <= w_lives_d;
      r_err   <= w_err_d;
      r_pend  <= w_pend_d;
      r_wdog  <= w_wdog_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_lives_d = r_lives;
    w_err_d   = r_err;
    w_pend_d  = r_pend;
    w_wdog_d  = r_wdog;
    w_timeout = 1'b0;

    if (enable) begin
      case (r_state)
        StGreeting: begin
          if (greet_done) w_state_d = StIdle;
        end
        StIdle: begin
          if (w_start_key) begin
            w_state_d = StWait;
            w_lives_d = LIFE_W'(LIVES);
            w_err_d   = 1'b0;
            w_pend_d  = 1'b0;
          end
        end
        StWait: begin
          if (w_pause_key) w_pend_d = 1'b1;
          // A pending pause wins over a same-cycle frame tick.
          if (r_pend) w_state_d = StPaused;
          else if (frame_tick) w_state_d = StLogic;
        end
        StLogic: begin
          if (w_pause_key) w_pend_d = 1'b1;
          if (logic_done) begin
            if (!collided) begin
              w_state_d = StRender;
            end else if (r_lives == LIFE_W'(1)) begin
              w_lives_d = '0;
              w_state_d = StGameOver;
            end else begin
              w_lives_d = r_lives - LIFE_W'(1);
              w_state_d = StRespawn;
            end
          end
        end
        StRender: begin
          if (w_pause_key) w_pend_d = 1'b1;
          if (render_done) w_state_d = StWait;
        end
        StRespawn: begin
          if (w_pause_key) w_pend_d = 1'b1;
          if (respawn_done) w_state_d = StRender;
        end
        StPaused: begin
          if (w_pause_key) w_state_d = StWait;
        end
        StGameOver: begin
          if (game_over_done) w_state_d = StGreeting;
        end
        default: w_state_d = StGreeting;
      endcase

      // A done on the last allowed cycle still wins over the watchdog.
      if ((WDOG != 0) && w_busy && (w_state_d == r_state) && (r_wdog == WdogLast)) begin
        w_timeout = 1'b1;
        w_state_d = StGreeting;
        w_err_d   = 1'b1;
      end

      // Timeout in GREETING keeps the state, so it must restart the count explicitly.
      if ((w_state_d != r_state) || w_timeout || !w_busy) w_wdog_d = '0;
      else w_wdog_d = r_wdog + 32'd1;

      if ((w_state_d != r_state) && ((w_state_d == StPaused) || (w_state_d == StIdle))) begin
        w_pend_d = 1'b0;
      end
    end
  end

  assign e_greet     = (r_state == StGreeting);
  assign e_logic     = (r_state == StLogic);
  assign e_render    = (r_state == StRender);
  assign e_respawn   = (r_state == StRespawn);
  assign e_game_over = (r_state == StGameOver);

  assign lives       = r_lives;
  assign state_out   = r_state;
  assign err_timeout = r_err;

  always_comb begin
    VGA_X     = '0;
    VGA_Y     = '0;
    VGA_COLOR = '0;
    VGA_WRITE = 1'b0;
    case (r_state)
      StGreeting: begin
        VGA_X     = src_x[0*X_W +: X_W];
        VGA_Y     = src_y[0*Y_W +: Y_W];
        VGA_COLOR = src_color[0*COLOR_W +: COLOR_W];
        VGA_WRITE = src_write[0];
      end
      StRender, StRespawn: begin
        VGA_X     = src_x[1*X_W +: X_W];
        VGA_Y     = src_y[1*Y_W +: Y_W];
        VGA_COLOR = src_color[1*COLOR_W +: COLOR_W];
        VGA_WRITE = src_write[1];
      end
      StGameOver: begin
        VGA_X     = src_x[2*X_W +: X_W];
        VGA_Y     = src_y[2*Y_W +: Y_W];
        VGA_COLOR = src_color[2*COLOR_W +: COLOR_W];
        VGA_WRITE = src_write[2];
      end
      default: begin
        VGA_X     = '0;
        VGA_Y     = '0;
        VGA_COLOR = '0;
        VGA_WRITE = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_m_game_sequencer.sv
// Testbench for m_game_sequencer: directed stimulus, a per-cycle comparison against a
// behavioural model of the game flow, and literal checks at key points.
module tb_m_game_sequencer;

  localparam int XW = 8;
  localparam int YW = 7;
  localparam int CW = 12;
  localparam int WD = 16;

  logic            clock = 1'b0;
  logic            resetn = 1'b0;
  logic            enable = 1'b1;
  logic            key_valid = 1'b0;
  logic [7:0]      key_code = 8'h00;
  logic            frame_tick = 1'b0;
  logic            greet_done = 1'b0;
  logic            logic_done = 1'b0;
  logic            render_done = 1'b0;
  logic            respawn_done = 1'b0;
  logic            game_over_done = 1'b0;
  logic            collided = 1'b0;
  logic [3*XW-1:0] src_x = {8'hC3, 8'h5A, 8'h11};
  logic [3*YW-1:0] src_y = {7'h33, 7'h2A, 7'h05};
  logic [3*CW-1:0] src_color = {12'hF00, 12'h0F0, 12'h00F};
  logic [2:0]      src_write = 3'b111;

  logic            e_greet, e_logic, e_render, e_respawn, e_game_over;
  logic [XW-1:0]   vga_x;
  logic [YW-1:0]   vga_y;
  logic [CW-1:0]   vga_color;
  logic            vga_write;
  logic [1:0]      lives;
  logic [2:0]      state_out;
  logic            err_timeout;

  int n_total = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  m_game_sequencer #(
    .X_W(XW), .Y_W(YW), .COLOR_W(CW), .LIVES(3), .LIFE_W(2),
    .START_KEY(8'h29), .PAUSE_KEY(8'h4D), .WDOG(WD)
  ) dut (
    .clock(clock), .resetn(resetn), .enable(enable),
    .key_valid(key_valid), .key_code(key_code), .frame_tick(frame_tick),
    .e_greet(e_greet), .e_logic(e_logic), .e_render(e_render),
    .e_respawn(e_respawn), .e_game_over(e_game_over),
    .greet_done(greet_done), .logic_done(logic_done), .render_done(render_done),
    .respawn_done(respawn_done), .game_over_done(game_over_done), .collided(collided),
    .src_x(src_x), .src_y(src_y), .src_color(src_color), .src_write(src_write),
    .VGA_X(vga_x), .VGA_Y(vga_y), .VGA_COLOR(vga_color), .VGA_WRITE(vga_write),
    .lives(lives), .state_out(state_out), .err_timeout(err_timeout)
  );

  initial forever #5 clock = ~clock;

  // Model of the game: phase number, lives, error flag, pause request and the
  // number of cycles already spent in the current phase.
  typedef struct {
    int st;
    int lv;
    bit err;
    bit pend;
    int age;
  } mstate_t;

  mstate_t m = '{st: 0, lv: 0, err: 1'b0, pend: 1'b0, age: 1};

  function automatic mstate_t model_next(mstate_t s);
    mstate_t n = s;
    bit start = key_valid && (key_code == 8'h29);
    bit pk = key_valid && (key_code == 8'h4D);
    bit busy = (s.st == 0) || (s.st == 3) || (s.st == 4) || (s.st == 5) || (s.st == 7);
    bit to;
    if (s.st == 0 && greet_done) n.st = 1;
    if (s.st == 1 && start) begin
      n.st = 2; n.lv = 3; n.err = 1'b0; n.pend = 1'b0;
    end
    if (s.st == 2) n.st = s.pend ? 6 : (frame_tick ? 3 : 2);
    if (s.st == 3 && logic_done) begin
      if (!collided) n.st = 4;
      else if (s.lv == 1) begin n.lv = 0; n.st = 7; end
      else begin n.lv = s.lv - 1; n.st = 5; end
    end
    if (s.st == 4 && render_done) n.st = 2;
    if (s.st == 5 && respawn_done) n.st = 4;
    if (s.st == 6 && pk) n.st = 2;
    if (s.st == 7 && game_over_done) n.st = 0;
    if (pk && (s.st >= 2 && s.st <= 5)) n.pend = 1'b1;
    to = busy && (n.st == s.st) && (s.age == WD);
    if (to) begin n.st = 0; n.err = 1'b1; end
    n.age = (to || n.st != s.st) ? 1 : s.age + 1;
    if (n.st != s.st && (n.st == 6 || n.st == 1)) n.pend = 1'b0;
    return n;
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) m <= '{st: 0, lv: 0, err: 1'b0, pend: 1'b0, age: 1};
    else if (enable) m <= model_next(m);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      int idx;
      logic [XW-1:0] ex;
      logic [YW-1:0] ey;
      logic [CW-1:0] ec;
      logic ew;
      idx = (m.st == 0) ? 0 : ((m.st == 4 || m.st == 5) ? 1 : ((m.st == 7) ? 2 : -1));
      ex = '0; ey = '0; ec = '0; ew = 1'b0;
      if (idx >= 0) begin
        ex = src_x[idx*XW +: XW];
        ey = src_y[idx*YW +: YW];
        ec = src_color[idx*CW +: CW];
        ew = src_write[idx];
      end
      chk("state", 64'(state_out), 64'(m.st));
      chk("enables", 64'({e_greet, e_logic, e_render, e_respawn, e_game_over}),
          64'({m.st == 0, m.st == 3, m.st == 4, m.st == 5, m.st == 7}));
      chk("lives", 64'(lives), 64'(m.lv));
      chk("err_timeout", 64'(err_timeout), 64'(m.err));
      chk("vga_bus", 64'({vga_write, vga_color, vga_y, vga_x}), 64'({ew, ec, ey, ex}));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [7:0] k);
    key_valid = 1'b1; key_code = k;
    cyc(1);
    key_valid = 1'b0; key_code = 8'h00;
  endtask

  // 0 greet, 1 logic, 2 render, 3 respawn, 4 game over, 5 frame tick
  task automatic strobe(input int which);
    case (which)
      0: greet_done = 1'b1;
      1: logic_done = 1'b1;
      2: render_done = 1'b1;
      3: respawn_done = 1'b1;
      4: game_over_done = 1'b1;
      default: frame_tick = 1'b1;
    endcase
    cyc(1);
    {greet_done, logic_done, render_done, respawn_done, game_over_done, frame_tick} = '0;
  endtask

  initial begin
    #23 resetn = 1'b1;
    chk_en = 1'b1;
    cyc(1);
    // Reset state
    chk("rst_state", 64'(state_out), 64'd0);
    chk("rst_e_greet", 64'(e_greet), 64'd1);
    chk("rst_lives", 64'(lives), 64'd0);
    chk("rst_vga_x", 64'(vga_x), 64'h11);

    // Start sequence; a pause key and a stray done in GREETING/IDLE are ignored
    press(8'h4D);
    strobe(2);
    chk("greet_hold", 64'(state_out), 64'd0);
    strobe(0);
    chk("to_idle", 64'(state_out), 64'd1);
    press(8'h4D);
    chk("idle_other_key", 64'(state_out), 64'd1);
    press(8'h29);
    chk("to_wait", 64'(state_out), 64'd2);
    chk("lives_loaded", 64'(lives), 64'd3);

    // Normal step
    strobe(2);
    chk("wait_ignores_done", 64'(state_out), 64'd2);
    strobe(5);
    chk("to_logic", 64'(state_out), 64'd3);
    cyc(2);
    strobe(1);
    chk("to_render", 64'(state_out), 64'd4);
    chk("render_vga_color", 64'(vga_color), 64'h0F0);
    cyc(1);
    strobe(2);
    chk("back_wait", 64'(state_out), 64'd2);
    chk("wait_vga_write", 64'(vga_write), 64'd0);

    // Three collisions
    collided = 1'b1;
    for (int i = 0; i < 2; i++) begin
      strobe(5);
      strobe(1);
      chk("to_respawn", 64'(state_out), 64'd5);
      chk("lives_dec", 64'(lives), 64'(2 - i));
      strobe(3);
      strobe(2);
    end
    strobe(5);
    strobe(1);
    collided = 1'b0;
    chk("to_game_over", 64'(state_out), 64'd7);
    chk("lives_zero", 64'(lives), 64'd0);
    chk("over_vga_x", 64'(vga_x), 64'hC3);
    strobe(4);
    chk("over_to_greet", 64'(state_out), 64'd0);
    strobe(0);
    press(8'h29);
    chk("restart_lives", 64'(lives), 64'd3);

    // Pause via pending from RENDER
    strobe(5);
    strobe(1);
    press(8'h4D);
    chk("render_holds", 64'(state_out), 64'd4);
    strobe(2);
    chk("pending_wait", 64'(state_out), 64'd2);
    cyc(1);
    chk("paused", 64'(state_out), 64'd6);
    strobe(5);
    cyc(20);
    chk("paused_hold", 64'(state_out), 64'd6);
    press(8'h4D);
    chk("resume", 64'(state_out), 64'd2);
    press(8'h4D);
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    chk("pending_beats_tick", 64'(state_out), 64'd6);
    press(8'h4D);

    // Pixel write sources swapped to expose mux selection
    src_write = 3'b010;
    src_x = {8'h9E, 8'h47, 8'h2B};

    // Watchdog in LOGIC
    strobe(5);
    cyc(WD - 1);
    chk("wdog_not_yet", 64'(state_out), 64'd3);
    cyc(1);
    chk("wdog_fired", 64'(state_out), 64'd0);
    chk("wdog_err", 64'(err_timeout), 64'd1);
    chk("greet_write_off", 64'(vga_write), 64'd0);
    strobe(0);
    chk("err_sticky", 64'(err_timeout), 64'd1);
    press(8'h29);
    chk("err_cleared", 64'(err_timeout), 64'd0);

    // Enable low freezes LOGIC even with logic_done held
    strobe(5);
    enable = 1'b0;
    logic_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("frozen", 64'(state_out), 64'd3);
    end
    logic_done = 1'b0;
    enable = 1'b1;
    cyc(2);
    chk("thawed_logic", 64'(state_out), 64'd3);
    strobe(1);
    chk("render_write_on", 64'(vga_write), 64'd1);
    chk("render_x_src1", 64'(vga_x), 64'h47);
    strobe(2);
    chk("final_wait", 64'(state_out), 64'd2);
    cyc(2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
